// File: rtl/memory_arbiter_if.sv
// Request/response and block-memory bus shared by the arbiter and its neighbours.
// slave = arbiter side, master = requesters plus memory side.
interface memory_arbiter_if #(
  parameter int ADDRESS_SIZE = 10,
  parameter int WORD_SIZE    = 32
);
  localparam int BYTES = WORD_SIZE / 8;

  logic                    fetch_request_valid;
  logic [ADDRESS_SIZE-1:0] fetch_address;
  logic                    fetch_ready;
  logic                    fetch_response_valid;
  logic [WORD_SIZE-1:0]    fetch_data;

  logic                    data_request_valid;
  logic                    data_write;
  logic [BYTES-1:0]        data_byte_enable;
  logic [ADDRESS_SIZE-1:0] data_address;
  logic [WORD_SIZE-1:0]    data_write_data;
  logic                    data_ready;
  logic                    data_response_valid;
  logic [WORD_SIZE-1:0]    data_read_data;

  logic                    mem_read_enable;
  logic                    mem_write_enable;
  logic [ADDRESS_SIZE-1:0] mem_read_address;
  logic [ADDRESS_SIZE-1:0] mem_write_address;
  logic [WORD_SIZE-1:0]    mem_write_data;
  logic [WORD_SIZE-1:0]    mem_read_data;

  modport slave (
    input  fetch_request_valid, fetch_address,
    output fetch_ready, fetch_response_valid, fetch_data,
    input  data_request_valid, data_write, data_byte_enable, data_address, data_write_data,
    output data_ready, data_response_valid, data_read_data,
    output mem_read_enable, mem_write_enable, mem_read_address, mem_write_address, mem_write_data,
    input  mem_read_data
  );

  modport master (
    output fetch_request_valid, fetch_address,
    input  fetch_ready, fetch_response_valid, fetch_data,
    output data_request_valid, data_write, data_byte_enable, data_address, data_write_data,
    input  data_ready, data_response_valid, data_read_data,
    input  mem_read_enable, mem_write_enable, mem_read_address, mem_write_address, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one block memory between instruction fetch and
// load/store. Partial-mask stores become a read-modify-write over two cycles.
module memory_arbiter #(
  parameter int ADDRESS_SIZE = 10,
  parameter int WORD_SIZE    = 32
) (
  input  logic              clk,
  input  logic              reset,
  memory_arbiter_if.slave   bus
);
  localparam int BYTES = WORD_SIZE / 8;

  typedef enum logic [1:0] {IDLE, READ_RESP, RMW_WRITE, WRITE_ACK} state_t;

  state_t                  state, next_state;
  logic                    last_grant_data, next_last_grant_data;
  logic                    resp_fetch, next_resp_fetch;
  logic [ADDRESS_SIZE-1:0] lat_addr, next_lat_addr;
  logic [BYTES-1:0]        lat_mask, next_lat_mask;
  logic [WORD_SIZE-1:0]    lat_data, next_lat_data;
  logic [WORD_SIZE-1:0]    merged;
  logic                    grant_fetch, grant_data;

  // Byte merge for the write half of a read-modify-write.
  for (genvar i = 0; i < BYTES; i++) begin : g_merge
    assign merged[8*i +: 8] = lat_mask[i] ? lat_data[8*i +: 8] : bus.mem_read_data[8*i +: 8];
  end

  // Arbitration: a lone requester wins; on a tie the side not granted last wins.
  always_comb begin
    grant_fetch = (state == IDLE) && bus.fetch_request_valid &&
                  (!bus.data_request_valid || last_grant_data);
    grant_data  = (state == IDLE) && bus.data_request_valid &&
                  (!bus.fetch_request_valid || !last_grant_data);
  end

  // Next-state and outputs; everything held at 0 while reset is asserted.
  always_comb begin
    next_state           = state;
    next_last_grant_data = last_grant_data;
    next_resp_fetch      = resp_fetch;
    next_lat_addr        = lat_addr;
    next_lat_mask        = lat_mask;
    next_lat_data        = lat_data;
    bus.fetch_ready          = 1'b0;
    bus.fetch_response_valid = 1'b0;
    bus.fetch_data           = '0;
    bus.data_ready           = 1'b0;
    bus.data_response_valid  = 1'b0;
    bus.data_read_data       = '0;
    bus.mem_read_enable      = 1'b0;
    bus.mem_write_enable     = 1'b0;
    bus.mem_read_address     = '0;
    bus.mem_write_address    = '0;
    bus.mem_write_data       = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          bus.fetch_ready = grant_fetch;
          bus.data_ready  = grant_data;
          if (grant_fetch) begin
            bus.mem_read_enable  = 1'b1;
            bus.mem_read_address = bus.fetch_address;
            next_last_grant_data = 1'b0;
            next_resp_fetch      = 1'b1;
            next_state           = READ_RESP;
          end else if (grant_data) begin
            next_last_grant_data = 1'b1;
            next_resp_fetch      = 1'b0;
            if (!bus.data_write) begin
              bus.mem_read_enable  = 1'b1;
              bus.mem_read_address = bus.data_address;
              next_state           = READ_RESP;
            end else if (&bus.data_byte_enable) begin
              bus.mem_write_enable  = 1'b1;
              bus.mem_write_address = bus.data_address;
              bus.mem_write_data    = bus.data_write_data;
              next_state            = WRITE_ACK;
            end else if (bus.data_byte_enable == '0) begin
              next_state = WRITE_ACK;
            end else begin
              bus.mem_read_enable  = 1'b1;
              bus.mem_read_address = bus.data_address;
              next_lat_addr        = bus.data_address;
              next_lat_mask        = bus.data_byte_enable;
              next_lat_data        = bus.data_write_data;
              next_state           = RMW_WRITE;
            end
          end
        end
        READ_RESP: begin
          if (resp_fetch) begin
            bus.fetch_response_valid = 1'b1;
            bus.fetch_data           = bus.mem_read_data;
          end else begin
            bus.data_response_valid = 1'b1;
            bus.data_read_data      = bus.mem_read_data;
          end
          next_state = IDLE;
        end
        RMW_WRITE: begin
          bus.mem_write_enable    = 1'b1;
          bus.mem_write_address   = lat_addr;
          bus.mem_write_data      = merged;
          bus.data_response_valid = 1'b1;
          next_state              = IDLE;
        end
        WRITE_ACK: begin
          bus.data_response_valid = 1'b1;
          next_state              = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // State and latched-request registers; reset biases the first tie to fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      last_grant_data <= 1'b1;
      resp_fetch      <= 1'b0;
      lat_addr        <= '0;
      lat_mask        <= '0;
      lat_data        <= '0;
    end else begin
      state           <= next_state;
      last_grant_data <= next_last_grant_data;
      resp_fetch      <= next_resp_fetch;
      lat_addr        <= next_lat_addr;
      lat_mask        <= next_lat_mask;
      lat_data        <= next_lat_data;
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a behavioural 1-cycle-read block memory.
module tb_memory_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  memory_arbiter_if #(.ADDRESS_SIZE(AW), .WORD_SIZE(DW)) bus ();
  memory_arbiter #(.ADDRESS_SIZE(AW), .WORD_SIZE(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Block memory model: write at edge, registered read.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdata = '0;
  always @(posedge clk) begin
    if (bus.mem_write_enable) mem[bus.mem_write_address] <= bus.mem_write_data;
    if (bus.mem_read_enable)  rdata <= mem[bus.mem_read_address];
  end
  assign bus.mem_read_data = rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic all_zero(input string tag);
    logic [31:0] v;
    v = {22'd0, bus.fetch_ready, bus.data_ready, bus.fetch_response_valid,
         bus.data_response_valid, bus.mem_read_enable, bus.mem_write_enable,
         |bus.mem_read_address, |bus.mem_write_address, |bus.mem_write_data,
         |bus.fetch_data | |bus.data_read_data};
    chk(tag, v, 32'd0);
  endtask

  int accepts;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    mem[5]  <= 32'hDEADBEEF;
    mem[6]  <= 32'h66666666;
    mem[7]  <= 32'h77777777;
    mem[3]  <= 32'h11223344;
    mem[10] <= 32'hCAFEF00D;
    mem[12] <= 32'h01020304;

    reset = 1'b1;
    bus.fetch_request_valid = 1'b1;
    bus.fetch_address       = '0;
    bus.data_request_valid  = 1'b1;
    bus.data_write          = 1'b0;
    bus.data_byte_enable    = '0;
    bus.data_address        = '0;
    bus.data_write_data     = '0;

    // Reset held two cycles with both requesters active.
    step; @(negedge clk); all_zero("reset_c0");
    step; @(negedge clk); all_zero("reset_c1");
    step; reset = 1'b0;
    @(negedge clk);
    chk("post_reset_fetch_ready", 32'(bus.fetch_ready), 32'd1);
    chk("post_reset_data_ready", 32'(bus.data_ready), 32'd0);
    step; bus.fetch_request_valid = 1'b0; bus.data_request_valid = 1'b0;
    step;

    // Fetch read of address 5.
    bus.fetch_request_valid = 1'b1; bus.fetch_address = 10'd5;
    @(negedge clk);
    chk("fetch_ready_N", 32'(bus.fetch_ready), 32'd1);
    chk("fetch_rd_en_N", 32'(bus.mem_read_enable), 32'd1);
    chk("fetch_rd_addr_N", 32'(bus.mem_read_address), 32'd5);
    step; bus.fetch_request_valid = 1'b0;
    @(negedge clk);
    chk("fetch_resp_valid", 32'(bus.fetch_response_valid), 32'd1);
    chk("fetch_data", bus.fetch_data, 32'hDEADBEEF);
    chk("fetch_ready_N1", 32'(bus.fetch_ready), 32'd0);
    step;

    // Round-robin: last grant was fetch, so data goes first.
    bus.fetch_request_valid = 1'b1; bus.fetch_address = 10'd6;
    bus.data_request_valid  = 1'b1; bus.data_write = 1'b0; bus.data_address = 10'd7;
    accepts = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("rr_fetch_ready_c%0d", c), 32'(bus.fetch_ready), 32'((c % 4) == 2));
      chk($sformatf("rr_data_ready_c%0d", c), 32'(bus.data_ready), 32'((c % 4) == 0));
      if (bus.fetch_ready || bus.data_ready) accepts++;
      if ((c % 4) == 1) chk($sformatf("rr_data_rd_c%0d", c), bus.data_read_data, 32'h77777777);
      if ((c % 4) == 3) chk($sformatf("rr_fetch_rd_c%0d", c), bus.fetch_data, 32'h66666666);
      step;
    end
    bus.fetch_request_valid = 1'b0; bus.data_request_valid = 1'b0;
    chk("rr_accepts", 32'(accepts), 32'd4);
    step;

    // Partial store 0xAABBCCDD mask 0101 into 0x11223344.
    bus.data_request_valid = 1'b1; bus.data_write = 1'b1; bus.data_address = 10'd3;
    bus.data_byte_enable = 4'b0101; bus.data_write_data = 32'hAABBCCDD;
    @(negedge clk);
    chk("rmw_ready", 32'(bus.data_ready), 32'd1);
    chk("rmw_rd_en", 32'(bus.mem_read_enable), 32'd1);
    chk("rmw_rd_addr", 32'(bus.mem_read_address), 32'd3);
    chk("rmw_no_wr_N", 32'(bus.mem_write_enable), 32'd0);
    step; bus.data_request_valid = 1'b0;
    @(negedge clk);
    chk("rmw_wr_en", 32'(bus.mem_write_enable), 32'd1);
    chk("rmw_wr_addr", 32'(bus.mem_write_address), 32'd3);
    chk("rmw_wr_data", bus.mem_write_data, 32'h11BB33DD);
    chk("rmw_ack", 32'(bus.data_response_valid), 32'd1);
    step;
    // Load straight back: must see the merged word.
    bus.data_request_valid = 1'b1; bus.data_write = 1'b0; bus.data_address = 10'd3;
    @(negedge clk);
    chk("rmw_load_ready", 32'(bus.data_ready), 32'd1);
    step; bus.data_request_valid = 1'b0;
    @(negedge clk);
    chk("rmw_load_valid", 32'(bus.data_response_valid), 32'd1);
    chk("rmw_load_data", bus.data_read_data, 32'h11BB33DD);
    step;

    // Full-mask store: single-cycle write.
    bus.data_request_valid = 1'b1; bus.data_write = 1'b1; bus.data_address = 10'd9;
    bus.data_byte_enable = 4'b1111; bus.data_write_data = 32'h12345678;
    @(negedge clk);
    chk("full_wr_en", 32'(bus.mem_write_enable), 32'd1);
    chk("full_wr_addr", 32'(bus.mem_write_address), 32'd9);
    chk("full_wr_data", bus.mem_write_data, 32'h12345678);
    chk("full_no_rd", 32'(bus.mem_read_enable), 32'd0);
    step; bus.data_request_valid = 1'b0;
    @(negedge clk);
    chk("full_ack", 32'(bus.data_response_valid), 32'd1);
    chk("full_no_wr_N1", 32'(bus.mem_write_enable), 32'd0);
    chk("full_mem", mem[9], 32'h12345678);
    step;

    // Empty-mask store: ack only, memory untouched.
    bus.data_request_valid = 1'b1; bus.data_write = 1'b1; bus.data_address = 10'd10;
    bus.data_byte_enable = 4'b0000; bus.data_write_data = 32'hFFFFFFFF;
    @(negedge clk);
    chk("empty_ready", 32'(bus.data_ready), 32'd1);
    chk("empty_no_wr", 32'(bus.mem_write_enable), 32'd0);
    chk("empty_no_rd", 32'(bus.mem_read_enable), 32'd0);
    step; bus.data_request_valid = 1'b0;
    @(negedge clk);
    chk("empty_ack", 32'(bus.data_response_valid), 32'd1);
    chk("empty_no_wr_N1", 32'(bus.mem_write_enable), 32'd0);
    step;
    chk("empty_mem", mem[10], 32'hCAFEF00D);

    // Reset while in RMW_WRITE: write and ack must be dropped.
    bus.data_request_valid = 1'b1; bus.data_write = 1'b1; bus.data_address = 10'd12;
    bus.data_byte_enable = 4'b0011; bus.data_write_data = 32'hFFFFFFFF;
    @(negedge clk);
    chk("rst_rmw_ready", 32'(bus.data_ready), 32'd1);
    step; bus.data_request_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("rst_rmw_no_wr", 32'(bus.mem_write_enable), 32'd0);
    chk("rst_rmw_no_ack", 32'(bus.data_response_valid), 32'd0);
    step; reset = 1'b0;
    bus.fetch_request_valid = 1'b1; bus.fetch_address = 10'd0;
    bus.data_request_valid  = 1'b1; bus.data_write = 1'b0;
    @(negedge clk);
    chk("rst_rmw_no_ack_after", 32'(bus.data_response_valid), 32'd0);
    chk("rst_tie_fetch", 32'(bus.fetch_ready), 32'd1);
    chk("rst_tie_data", 32'(bus.data_ready), 32'd0);
    chk("rst_rmw_mem", mem[12], 32'h01020304);
    step; bus.fetch_request_valid = 1'b0; bus.data_request_valid = 1'b0;
    step; step;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
